mc_ctrl: RTL and testbench

Multi-cycle main controller for the MIPS core. Each cycle it decodes the registered instruction word (opcode/funct) and its current state, and sequences the IFU, register file, ALU, EXT and DM through FETCH/DECODE/EXECUTE/MEM/WB. It drives the IFU's `nPC_sel` and a PC write enable so PC advances exactly once per instruction. `IR_en` loads the instruction register.

---
 rtl/mc_ctrl.sv | 147 ++++++++++++++
 tb/tb_mc_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS main controller: FETCH/DECODE/EXECUTE/MEM/WB sequencing, 2-5 cycles per instruction.
// Outputs are a combinational decode of state+IR fields; no backpressure, state advances every cycle.
module mc_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       cmp,
  output logic       IR_en,
  output logic       PC_en,
  output logic [2:0] nPC_sel,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic       ALUSrc,
  output logic [2:0] ALUOp,
  output logic [1:0] EXTOp,
  output logic       MemWrite,
  output logic       retire,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_ALU_R    = 4'd2;
  localparam logic [3:0] S_ALU_I    = 4'd3;
  localparam logic [3:0] S_WB_ALU   = 4'd4;
  localparam logic [3:0] S_MEM_ADDR = 4'd5;
  localparam logic [3:0] S_MEM_RD   = 4'd6;
  localparam logic [3:0] S_MEM_WR   = 4'd7;
  localparam logic [3:0] S_WB_MEM   = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JUMP     = 4'd10;

  logic [3:0] nxt_state;
  logic       is_r, is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;

  // The branch comparison is resolved inside the IFU.
  logic unused_cmp;
  assign unused_cmp = cmp;

  assign is_r    = (opcode == 6'b000000);
  assign is_addu = is_r && (funct == 6'b100001);
  assign is_subu = is_r && (funct == 6'b100011);
  assign is_jr   = is_r && (funct == 6'b001000);
  assign is_ori  = (opcode == 6'b001101);
  assign is_lui  = (opcode == 6'b001111);
  assign is_lw   = (opcode == 6'b100011);
  assign is_sw   = (opcode == 6'b101011);
  assign is_beq  = (opcode == 6'b000100);
  assign is_j    = (opcode == 6'b000010);
  assign is_jal  = (opcode == 6'b000011);

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= nxt_state;
  end

  always_comb begin
    nxt_state = S_FETCH;
    case (state)
      S_FETCH:  nxt_state = S_DECODE;
      S_DECODE: begin
        if (is_addu || is_subu)          nxt_state = S_ALU_R;
        else if (is_ori || is_lui)       nxt_state = S_ALU_I;
        else if (is_lw || is_sw)         nxt_state = S_MEM_ADDR;
        else if (is_beq)                 nxt_state = S_BRANCH;
        else if (is_j || is_jal || is_jr) nxt_state = S_JUMP;
        else                             nxt_state = S_FETCH;
      end
      S_ALU_R, S_ALU_I: nxt_state = S_WB_ALU;
      S_MEM_ADDR:       nxt_state = is_lw ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:         nxt_state = S_WB_MEM;
      default:          nxt_state = S_FETCH;
    endcase
  end

  always_comb begin
    IR_en    = 1'b0;
    PC_en    = 1'b0;
    nPC_sel  = 3'd0;
    RegWrite = 1'b0;
    RegDst   = 2'd0;
    MemtoReg = 2'd0;
    ALUSrc   = 1'b0;
    ALUOp    = 3'd0;
    EXTOp    = 2'd0;
    MemWrite = 1'b0;
    case (state)
      S_FETCH:  IR_en = 1'b1;
      S_DECODE: begin
        // nop and unrecognised encodings retire straight from DECODE.
        if (!(is_addu || is_subu || is_ori || is_lui || is_lw || is_sw ||
              is_beq || is_j || is_jal || is_jr)) PC_en = 1'b1;
      end
      S_ALU_R:  ALUOp = is_subu ? 3'd1 : 3'd0;
      S_ALU_I: begin
        ALUSrc = 1'b1;
        EXTOp  = is_lui ? 2'd2 : 2'd0;
        ALUOp  = is_lui ? 3'd3 : 3'd2;
      end
      S_WB_ALU: begin
        RegWrite = 1'b1;
        RegDst   = is_r ? 2'd1 : 2'd0;
        PC_en    = 1'b1;
      end
      S_MEM_ADDR: begin
        ALUSrc = 1'b1;
        EXTOp  = 2'd1;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        PC_en    = 1'b1;
      end
      S_WB_MEM: begin
        RegWrite = 1'b1;
        MemtoReg = 2'd1;
        PC_en    = 1'b1;
      end
      S_BRANCH: begin
        ALUOp   = 3'd1;
        PC_en   = 1'b1;
        nPC_sel = 3'd1;
      end
      S_JUMP: begin
        PC_en = 1'b1;
        if (is_jr) nPC_sel = 3'd2;
        else       nPC_sel = 3'd3;
        if (is_jal) begin
          RegWrite = 1'b1;
          RegDst   = 2'd2;
          MemtoReg = 2'd2;
        end
      end
      default: ;
    endcase
    // Reset suppresses every architectural write in the current cycle.
    if (reset) begin
      IR_en    = 1'b0;
      PC_en    = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
    end
    retire = PC_en;
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: directed and random instruction streams against a per-cycle model
// derived from instruction class and cycle index.
module tb_mc_ctrl;
  logic       clk, reset, cmp;
  logic [5:0] opcode, funct;
  logic       IR_en, PC_en, RegWrite, ALUSrc, MemWrite, retire;
  logic [2:0] nPC_sel, ALUOp;
  logic [1:0] RegDst, MemtoReg, EXTOp;
  logic [3:0] state;

  int checks = 0;
  int failures = 0;

  mc_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .cmp(cmp),
    .IR_en(IR_en), .PC_en(PC_en), .nPC_sel(nPC_sel), .RegWrite(RegWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrc(ALUSrc), .ALUOp(ALUOp),
    .EXTOp(EXTOp), .MemWrite(MemWrite), .retire(retire), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ir_en;
    logic       pc_en;
    logic [2:0] npc;
    logic       rw;
    logic [1:0] rd;
    logic [1:0] m2r;
    logic       als;
    logic [2:0] aop;
    logic [1:0] ext;
    logic       mw;
    logic       ret;
  } out_t;

  out_t obs;
  assign obs = '{IR_en, PC_en, nPC_sel, RegWrite, RegDst, MemtoReg, ALUSrc, ALUOp, EXTOp, MemWrite, retire};

  localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LUI = 3, K_LW = 4, K_SW = 5;
  localparam int K_BEQ = 6, K_J = 7, K_JAL = 8, K_JR = 9, K_NOP = 10;

  function automatic int classify(logic [5:0] op, logic [5:0] fn);
    case (op)
      6'b000000: begin
        if (fn == 6'b100001) return K_ADDU;
        if (fn == 6'b100011) return K_SUBU;
        if (fn == 6'b001000) return K_JR;
        return K_NOP;
      end
      6'b001101: return K_ORI;
      6'b001111: return K_LUI;
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000100: return K_BEQ;
      6'b000010: return K_J;
      6'b000011: return K_JAL;
      default:   return K_NOP;
    endcase
  endfunction

  function automatic int ncycles(int k);
    if (k == K_NOP) return 2;
    if (k == K_BEQ || k == K_J || k == K_JAL || k == K_JR) return 3;
    if (k == K_LW) return 5;
    return 4;
  endfunction

  // Expected outputs for cycle c (0 = FETCH) of an instruction of class k.
  function automatic out_t expect_at(int k, int c);
    out_t e;
    int   last;
    e = '0;
    last = ncycles(k) - 1;
    if (c == 0) e.ir_en = 1'b1;
    if (c == last) begin
      e.pc_en = 1'b1;
      if (k == K_BEQ) e.npc = 3'd1;
      else if (k == K_JR) e.npc = 3'd2;
      else if (k == K_J || k == K_JAL) e.npc = 3'd3;
    end
    if (c == 2) begin
      case (k)
        K_SUBU: e.aop = 3'd1;
        K_ORI:  begin e.als = 1'b1; e.ext = 2'd0; e.aop = 3'd2; end
        K_LUI:  begin e.als = 1'b1; e.ext = 2'd2; e.aop = 3'd3; end
        K_LW, K_SW: begin e.als = 1'b1; e.ext = 2'd1; end
        K_BEQ:  e.aop = 3'd1;
        K_JAL:  begin e.rw = 1'b1; e.rd = 2'd2; e.m2r = 2'd2; end
        default: ;
      endcase
    end
    if (c == 3) begin
      if (k == K_ADDU || k == K_SUBU) begin e.rw = 1'b1; e.rd = 2'd1; end
      if (k == K_ORI || k == K_LUI) e.rw = 1'b1;
      if (k == K_SW) e.mw = 1'b1;
    end
    if (c == 4 && k == K_LW) begin e.rw = 1'b1; e.m2r = 2'd1; end
    e.ret = e.pc_en;
    return e;
  endfunction

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Runs one instruction from FETCH; if rst_at >= 0, reset is raised at that cycle instead.
  task automatic run_instr(logic [5:0] op, logic [5:0] fn, int rst_at);
    int   k, n;
    out_t e;
    k = classify(op, fn);
    n = ncycles(k);
    for (int c = 0; c < n; c++) begin
      // IR is still loading in FETCH, so present unrelated bits there.
      opcode = (c == 0) ? 6'($urandom) : op;
      funct  = (c == 0) ? 6'($urandom) : fn;
      cmp    = 1'($urandom);
      if (c == rst_at) begin
        reset = 1'b1;
        @(negedge clk);
        chk("rst_enables", {28'd0, IR_en, PC_en, RegWrite, MemWrite}, 32'd0);
        chk("rst_retire", {31'd0, retire}, 32'd0);
        repeat (3) begin
          @(posedge clk); #1;
          @(negedge clk);
          chk("rst_hold_state", {28'd0, state}, 32'd0);
          chk("rst_hold_iren", {31'd0, IR_en}, 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        return;
      end
      @(negedge clk);
      e = expect_at(k, c);
      chk($sformatf("op%0b_fn%0b_c%0d", op, fn, c), 32'(obs), 32'(e));
      if (c == 0) chk("fetch_state", {28'd0, state}, 32'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [5:0] op, fn;
    clk = 1'b0; reset = 1'b1; opcode = '0; funct = '0; cmp = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_state", {28'd0, state}, 32'd0);
    chk("reset_enables", {28'd0, IR_en, PC_en, RegWrite, MemWrite}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_instr(6'b000000, 6'b100001, -1); // addu
    run_instr(6'b100011, 6'($urandom), -1); // lw
    run_instr(6'b101011, 6'($urandom), -1); // sw
    run_instr(6'b000100, 6'($urandom), -1); // beq
    run_instr(6'b000011, 6'($urandom), -1); // jal
    run_instr(6'b000000, 6'b001000, -1); // jr
    run_instr(6'b000010, 6'($urandom), -1); // j
    run_instr(6'b001101, 6'($urandom), -1); // ori
    run_instr(6'b001111, 6'($urandom), -1); // lui
    run_instr(6'b000000, 6'b100011, -1); // subu
    run_instr(6'b111111, 6'($urandom), -1); // unknown opcode
    run_instr(6'b000000, 6'b000000, -1); // nop
    run_instr(6'b100011, 6'd0, 3);       // reset in MEM_RD
    run_instr(6'b000000, 6'b100001, -1);
    run_instr(6'b100011, 6'd0, 4);       // reset in WB_MEM
    run_instr(6'b101011, 6'd0, -1);

    for (int i = 0; i < 80; i++) begin
      fn = 6'($urandom);
      if ($urandom_range(1, 0) == 1) begin
        case ($urandom_range(10, 0))
          0: begin op = 6'b000000; fn = 6'b100001; end
          1: begin op = 6'b000000; fn = 6'b100011; end
          2: begin op = 6'b000000; fn = 6'b001000; end
          3: op = 6'b001101;
          4: op = 6'b001111;
          5: op = 6'b100011;
          6: op = 6'b101011;
          7: op = 6'b000100;
          8: op = 6'b000010;
          9: op = 6'b000011;
          default: op = 6'b000000;
        endcase
      end else begin
        op = 6'($urandom);
      end
      run_instr(op, fn, ($urandom_range(15, 0) == 0) ? int'($urandom_range(4, 1)) : -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
